// File: rtl/token_rate_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : token_rate_scheduler
// Purpose  : Thins N serial token streams. Each channel keeps one token out of
//            every R_i tokens. Kept tokens wait in per-channel pending
//            counters. A round-robin arbiter merges them onto one registered
//            output token stream, and the channel ID is driven with each token.
// Revision : 1.0 - initial release
// ============================================================================
module token_rate_scheduler #(
    parameter int N      = 4,
    parameter int CNT_W  = 4,
    parameter int PEND_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         a,
    input  logic                 cfg_we,
    input  logic [$clog2(N)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]     cfg_ratio,
    output logic                 b,
    output logic [$clog2(N)-1:0] b_ch,
    output logic [N-1:0]         overflow
);

    localparam int                IDX_W     = $clog2(N);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [CNT_W-1:0]  RATIO_RST = CNT_W'(2);

    // Registered pending counts, gathered so the arbiter can scan them
    logic [PEND_W-1:0] pend [N];

    logic              grant_vld;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  last;
    logic [IDX_W:0]    scan;

    // Round-robin pick: first channel with pending tokens after 'last'.
    // The scan index carries one extra bit, so the wrap past N-1 is a single
    // subtract and no modulo is needed.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int k = 1; k <= N; k++) begin
            scan = {1'b0, last} + (IDX_W+1)'(k);
            if (scan >= (IDX_W+1)'(N)) begin
                scan = scan - (IDX_W+1)'(N);
            end
            if (!grant_vld && (pend[scan[IDX_W-1:0]] != '0)) begin
                grant_vld = 1'b1;
                grant_idx = scan[IDX_W-1:0];
            end
        end
    end

    // Output token register and arbiter pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            b    <= 1'b0;
            b_ch <= '0;
            last <= IDX_W'(N-1);
        end else begin
            b <= grant_vld;
            if (grant_vld) begin
                b_ch <= grant_idx;
                last <= grant_idx;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [CNT_W-1:0]  ratio_q;
        logic [CNT_W-1:0]  cnt_q;
        logic [PEND_W-1:0] pend_q;
        logic              ovf_q;
        logic              sel;
        logic              gnt;
        logic [CNT_W-1:0]  r_eff;
        logic [CNT_W-1:0]  c_eff;
        logic [CNT_W-1:0]  cnt_nxt;
        logic              kept;

        // A write to this channel takes effect for the token in the same cycle
        assign sel   = cfg_we && (cfg_ch == IDX_W'(i));
        assign r_eff = sel ? cfg_ratio : ratio_q;
        assign c_eff = sel ? '0 : cnt_q;
        assign gnt   = grant_vld && (grant_idx == IDX_W'(i));

        assign pend[i]     = pend_q;
        assign overflow[i] = ovf_q;

        // Divide decision. Ratios 0 and 1 both pass every token.
        always_comb begin
            kept    = 1'b0;
            cnt_nxt = c_eff;
            if (a[i]) begin
                if (r_eff <= CNT_W'(1)) begin
                    kept = 1'b1;
                end else if (c_eff == r_eff - CNT_W'(1)) begin
                    kept    = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = c_eff + CNT_W'(1);
                end
            end
        end

        // Ratio, divide count, pending count and sticky overflow
        always_ff @(posedge clk) begin
            if (rst) begin
                ratio_q <= RATIO_RST;
                cnt_q   <= '0;
                pend_q  <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (sel) begin
                    ratio_q <= cfg_ratio;
                end
                cnt_q <= cnt_nxt;
                if (kept && !gnt) begin
                    if (pend_q == PEND_MAX) begin
                        ovf_q <= 1'b1;
                    end else begin
                        pend_q <= pend_q + PEND_W'(1);
                    end
                end else if (gnt && !kept) begin
                    pend_q <= pend_q - PEND_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/token_rate_scheduler.md
Name: token_rate_scheduler

Overview:
Multi-channel token thinner and output scheduler. Each of N serial token inputs is reduced by a per-channel programmable ratio: one '1' is kept out of every R '1's, and R=2 is the halving case. Kept tokens are queued as per-channel pending counts and merged onto one shared serial token output through a round-robin arbiter, with the channel ID driven alongside each output token. The block sits between the serial token sources and the single downstream token consumer, and is configured by a simple register-write port.

Parameters:
N, 4, number of token input channels (>=2)
CNT_W, 4, width of per-channel ratio and divide counter
PEND_W, 3, width of per-channel pending-token counter (max 2^PEND_W-1 queued)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
a  input  N  serial token inputs; a[i]=1 is one token on channel i in that cycle
cfg_we  input  1  ratio write strobe
cfg_ch  input  $clog2(N)  channel selected for the ratio write
cfg_ratio  input  CNT_W  new keep ratio R for cfg_ch
b  output  1  merged output token, registered, one cycle per token
b_ch  output  $clog2(N)  channel of the current b token; holds its last value when b=0
overflow  output  N  sticky per-channel flag: a kept token was dropped because pending was full

Behaviour:
- Reset, synchronous, one cycle of rst=1:
  - b=0, b_ch=0, overflow=0.
  - All pending p_i=0 and all divide counts c_i=0.
  - All ratios R_i=2.
  - Round-robin pointer last=N-1, so channel 0 has first priority.
- Reset asserted mid-operation discards all pending tokens. No output token occurs in the cycle after rst.
- Divide stage, per channel, evaluated when a[i]=1:
  - If R_i<=1 (values 0 and 1 mean pass-all), the token is kept.
  - Else if c_i==R_i-1, the token is kept and c_i<=0.
  - Else c_i<=c_i+1 and nothing is kept.
  - a[i]=0 leaves c_i unchanged.
- Config write, cfg_we=1:
  - R[cfg_ch]<=cfg_ratio and c[cfg_ch] restarts from 0.
  - A token on a[cfg_ch] in the same cycle is evaluated with the new ratio and a count of 0. With new R<=1 it is kept; otherwise c becomes 1.
  - p and overflow are untouched. Other channels are unaffected.
- Pending update, per channel, each cycle: p_i_next = p_i + kept_i - grant_i.
  - Keep and grant in the same cycle leave p_i unchanged.
  - If kept_i and p_i==2^PEND_W-1 and not grant_i, the token is dropped, p_i stays, and overflow[i]<=1.
  - overflow clears only on rst.
- Arbiter, each cycle, uses the registered p values only:
  - Eligible channels are those with p_i>0.
  - The grant goes to the first eligible channel scanning last+1, last+2, ... modulo N; then last<=granted index.
  - With no eligible channel: no grant, last unchanged.
- Output:
  - On a grant, b<=1 and b_ch<=granted index at the same edge that p_i decrements.
  - Otherwise b<=0.
  - At most one output token per cycle.
- Latency: a token kept from a[i] sampled at edge k (p_i becomes nonzero at k) is granted at earliest at edge k+1. Minimum a-to-b latency is 2 cycles.
- Throughput: output total is 1 token/cycle. Each of K continuously eligible channels is served once every K cycles.
- Ordering: tokens leave in per-channel FIFO order. Across channels, order follows the round-robin rule only.
- Idle: with all p_i==0, b stays 0 indefinitely.

Test Plan:
1. Reset, then channel 0 at ratio 2 with a[0] = 110_011_101_000_1111 (other channels 0) -> b is 010_001_001_000_0101 delayed by 2 cycles, b_ch=0 on every pulse, 5 pulses total, overflow=0.
2. All ratios written to 1, a=4'b1111 for one cycle then 0 -> b=1 on 4 consecutive cycles with b_ch=0,1,2,3, then b=0; final last=3.
3. Ratio 1 on all channels, a=4'b1111 held for 20 cycles -> each p_i saturates at 7, overflow=4'b1111, and b=1 every cycle cycling b_ch 0,1,2,3. After a returns to 0, b drains 28 more tokens and then goes to 0.
4. Channel 2 at ratio 3 receives 5 tokens (c=2 before the write); then cfg_we writes ratio 4 to channel 2 in the same cycle as a token; then 6 more tokens arrive -> the 5 tokens yield exactly 1 kept; the write-cycle token leaves c=1; the 6 following tokens yield 1 kept on the 3rd; total 2 output pulses with b_ch=2.
5. Ratio 0 on channel 1 and a[1]=1 for 3 cycles -> 3 output tokens with b_ch=1, identical to ratio 1.
6. Fill channel 3 with 4 pending, assert rst for one cycle mid-drain -> b=0 in the cycle after reset, p=0, ratios back to 2, next grant goes to channel 0 first.
